video_timing: RTL and testbench

- Raster timing generator and pixel-alignment pipeline directly upstream of hdmi_encode, in the pixel clock domain.
- Walks horizontal/vertical counters and issues pixel coordinates to a fixed-latency pixel source (framebuffer/renderer).
- Re-times the returned RGB together with active, h_sync and v_sync, so the encoder sees all four aligned on the same cycle.

---
 rtl/video_timing.sv | 220 ++++++++++++++++++++++
 tb/tb_video_timing.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// Raster timing generator with a LATENCY-aligned output stage feeding hdmi_encode.
// Define VIDEO_TIMING_PATTERN_EN to add the pattern_sel input and the 8-bar colour generator.
module video_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_POLARITY = 0,
  parameter int V_POLARITY = 0,
  parameter int LATENCY    = 2,
  localparam int X_W = $clog2(H_ACTIVE),
  localparam int Y_W = $clog2(V_ACTIVE)
) (
  input  logic           clk,
  input  logic           reset,
`ifdef VIDEO_TIMING_PATTERN_EN
  input  logic           pattern_sel,
`endif
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           pixel_fetch,
  input  logic [23:0]    pixel_rgb,
  output logic           active,
  output logic           h_sync,
  output logic           v_sync,
  output logic [23:0]    rgb,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int BAR_W   = HC_W + 3;

  localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_C = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_C = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic            H_POL   = 1'(H_POLARITY);
  localparam logic            V_POL   = 1'(V_POLARITY);

  if (LATENCY < 1) begin : g_latency_check
    $error("video_timing: LATENCY must be >= 1");
  end

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
`ifdef VIDEO_TIMING_PATTERN_EN
    logic        pat;
    logic [23:0] pat_rgb;
`endif
  } stage_t;

  function automatic stage_t idle_stage();
    stage_t s;
    s    = '0;
    s.hs = ~H_POL;
    s.vs = ~V_POL;
    return s;
  endfunction

  logic [HC_W-1:0] h_q, h_d;
  logic [VC_W-1:0] v_q, v_d;
  logic            fetch_s;
  stage_t          stage_s;
  stage_t          dly_q [LATENCY];
  stage_t          dly_d [LATENCY];
  stage_t          last_s;
  logic            active_q, active_d;
  logic            h_sync_q, h_sync_d;
  logic            v_sync_q, v_sync_d;
  logic            frame_start_q, frame_start_d;
  logic [23:0]     rgb_q, rgb_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + VC_W'(1);
      end
    end else begin
      h_d = h_q + HC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

`ifdef VIDEO_TIMING_PATTERN_EN
  logic [BAR_W-1:0] bar_s;
  logic [23:0]      bar_rgb_s;

  // Bar index is pixel_x*8/H_ACTIVE; only meaningful while fetching, otherwise blanked later.
  always_comb begin
    bar_s = {h_q, 3'b000} / BAR_W'(H_ACTIVE);
    case (bar_s)
      BAR_W'(0): bar_rgb_s = 24'hFFFFFF;
      BAR_W'(1): bar_rgb_s = 24'hFFFF00;
      BAR_W'(2): bar_rgb_s = 24'h00FFFF;
      BAR_W'(3): bar_rgb_s = 24'h00FF00;
      BAR_W'(4): bar_rgb_s = 24'hFF00FF;
      BAR_W'(5): bar_rgb_s = 24'hFF0000;
      BAR_W'(6): bar_rgb_s = 24'h0000FF;
      default:   bar_rgb_s = 24'h000000;
    endcase
  end
`endif

  always_comb begin
    stage_s   = idle_stage();
    fetch_s   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    stage_s.act = fetch_s;
    if ((h_q >= HS_BEG) && (h_q < HS_END)) begin
      stage_s.hs = H_POL;
    end else begin
      stage_s.hs = ~H_POL;
    end
    if ((v_q >= VS_BEG) && (v_q < VS_END)) begin
      stage_s.vs = V_POL;
    end else begin
      stage_s.vs = ~V_POL;
    end
    stage_s.fs = (h_q == '0) && (v_q == '0);
`ifdef VIDEO_TIMING_PATTERN_EN
    stage_s.pat     = pattern_sel;
    stage_s.pat_rgb = bar_rgb_s;
`endif
  end

  assign pixel_fetch = fetch_s;
  assign pixel_x     = fetch_s ? h_q[X_W-1:0] : '0;
  assign pixel_y     = fetch_s ? v_q[Y_W-1:0] : '0;

  // Flags travel LATENCY stages so they meet pixel_rgb at the output register.
  always_comb begin
    dly_d[0] = stage_s;
    for (int i = 1; i < LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        dly_q[i] <= idle_stage();
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  assign last_s = dly_q[LATENCY-1];

  always_comb begin
    active_d      = last_s.act;
    h_sync_d      = last_s.hs;
    v_sync_d      = last_s.vs;
    frame_start_d = last_s.fs;
    rgb_d         = 24'h000000;
    if (last_s.act) begin
`ifdef VIDEO_TIMING_PATTERN_EN
      if (last_s.pat) begin
        rgb_d = last_s.pat_rgb;
      end else begin
        rgb_d = pixel_rgb;
      end
`else
      rgb_d = pixel_rgb;
`endif
    end else begin
      rgb_d = 24'h000000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      frame_start_q <= 1'b0;
      rgb_q         <= 24'h000000;
    end else begin
      active_q      <= active_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign active      = active_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing on a reduced raster (64x20 total, 40x12 active), LATENCY=2.
// Expected outputs come from a cycle-index model of the raster; a 2-stage source model answers fetches.
module tb_video_timing;

  localparam int HA = 40, HF = 4, HS = 8, HB = 12;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XW = $clog2(HA);
  localparam int YW = $clog2(VA);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          pixel_fetch;
  logic [23:0]   pixel_rgb;
  logic          active, h_sync, v_sync, frame_start;
  logic [23:0]   rgb;
`ifdef VIDEO_TIMING_PATTERN_EN
  logic          pattern_sel = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic src_white = 1'b0;

  logic          sr_f0 = 1'b0, sr_f1 = 1'b0;
  logic [XW-1:0] sr_x0 = '0, sr_x1 = '0;
  logic [YW-1:0] sr_y0 = '0, sr_y1 = '0;

  always #5 clk = ~clk;

  // Fixed two-cycle pixel source; returns junk outside fetched cycles.
  always @(posedge clk) begin
    sr_f0 <= pixel_fetch;
    sr_x0 <= pixel_x;
    sr_y0 <= pixel_y;
    sr_f1 <= sr_f0;
    sr_x1 <= sr_x0;
    sr_y1 <= sr_y0;
  end

  assign pixel_rgb = src_white ? 24'hFFFFFF :
                     (sr_f1 ? {8'(sr_y1), 8'(sr_x1), 8'h5A} : 24'hA5A5A5);

  video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POLARITY(0), .V_POLARITY(0), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef VIDEO_TIMING_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_fetch(pixel_fetch),
    .pixel_rgb(pixel_rgb),
    .active(active),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .rgb(rgb),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bar_colour(input int h);
    case (h * 8 / HA)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // k = cycles since counters left reset; outputs reflect counter state k-(LAT+1).
  task automatic check_cycle(input int k, input int mode);
    int p, h, v;
    logic e_act, e_hs, e_vs, e_fs, e_fetch;
    logic [23:0] e_rgb;
    e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 24'h0;
    if (k >= LAT + 1) begin
      p = k - (LAT + 1);
      h = p % HT;
      v = (p / HT) % VT;
      e_act = (h < HA) && (v < VA);
      e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      e_fs  = (h == 0) && (v == 0);
      if (e_act) begin
        case (mode)
          0:       e_rgb = {8'(v), 8'(h), 8'h5A};
          1:       e_rgb = 24'hFFFFFF;
          default: e_rgb = bar_colour(h);
        endcase
      end
    end
    chk("active", 32'(active), 32'(e_act));
    chk("h_sync", 32'(h_sync), 32'(e_hs));
    chk("v_sync", 32'(v_sync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("rgb", 32'(rgb), 32'(e_rgb));
    h = k % HT;
    v = (k / HT) % VT;
    e_fetch = (h < HA) && (v < VA);
    chk("pixel_fetch", 32'(pixel_fetch), 32'(e_fetch));
    chk("pixel_x", 32'(pixel_x), e_fetch ? 32'(h) : 32'd0);
    chk("pixel_y", 32'(pixel_y), e_fetch ? 32'(v) : 32'd0);
  endtask

  task automatic run(input int mode, input int ncyc);
    int last_fs;
    last_fs = -1;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) step();
      check_cycle(k, mode);
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) chk("fs_period", 32'(k - last_fs), 32'(HT * VT));
        last_fs = k;
      end
    end
  endtask

  task automatic check_reset();
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_h_sync", 32'(h_sync), 32'd1);
    chk("rst_v_sync", 32'(v_sync), 32'd1);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_fetch", 32'(pixel_fetch), 32'd1);
    chk("rst_x", 32'(pixel_x), 32'd0);
    chk("rst_y", 32'(pixel_y), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (5) step();
    check_reset();
    reset = 1'b0;
    run(0, 2 * HT * VT + 100);

    reset = 1'b1;
    step();
    check_reset();
    reset = 1'b0;
    run(0, 5 * HT + 30);

    reset = 1'b1;
    step();
    check_reset();
    step();
    check_reset();
    reset = 1'b0;
    run(0, HT * VT + 200);

    src_white = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    check_reset();
    reset = 1'b0;
    run(1, HT * VT + 50);

`ifdef VIDEO_TIMING_PATTERN_EN
    src_white = 1'b0;
    pattern_sel = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    check_reset();
    reset = 1'b0;
    run(2, HT * VT + 50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
